tdi_axis_line_splitter: RTL and testbench
=========================================

Name: tdi_axis_line_splitter

Overview:
- Sits between TDI_data_proc_top and the two RDMA_proc_top channels, in the sysclk_200 domain.
- Takes a single 512-bit AXI-Stream of TDI lines, each line terminated by tlast.
- Distributes whole lines to two channel outputs, either alternating channel by channel or broadcast to both.
- Gates new lines with the DDR write-enable and keeps per-channel line counters for status.

Parameters:
- DATA_WIDTH, 512, AXIS tdata width on all ports.
- CNT_WIDTH, 32, width of the per-channel line counters.

Ports:
- clk  in  1  sysclk_200; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  db_write_enable; new lines are accepted only while high.
- bcast_mode  in  1  0 = alternate lines ch0/ch1; 1 = duplicate every line to both channels.
- sync_clear  in  1  1-cycle pulse; resets the channel pointer and the counters.
- s_axis_tdata  in  DATA_WIDTH  input beat.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last beat of line.
- m0_axis_tdata  out  DATA_WIDTH  channel 0 beat.
- m0_axis_tvalid  out  1  channel 0 valid.
- m0_axis_tready  in  1  channel 0 ready.
- m0_axis_tlast  out  1  channel 0 last.
- m1_axis_tdata, m1_axis_tvalid, m1_axis_tready, m1_axis_tlast: same as m0 for channel 1.
- line_cnt_0  out  CNT_WIDTH  lines fully delivered on ch0 (tlast handshake on m0).
- line_cnt_1  out  CNT_WIDTH  same for ch1.
- busy  out  1  high while a line is in progress (mid-line).

Behaviour:
- Reset, asynchronous on rst_n low:
  - Both output buffers empty, so m0/m1_tvalid = 0; tdata and tlast = 0.
  - s_axis_tready = 0, sel = 0 (ch0), busy = 0, line_cnt_0/1 = 0, latched mode = 0.
- Each channel has a 2-entry FIFO holding {tdata, tlast}, with occupancy cnt in 0..2.
  - m*_tvalid = (cnt != 0); the head entry drives tdata/tlast.
  - Pop on m*_tvalid && m*_tready.
  - Push and pop in the same cycle leave cnt unchanged.
- FSM states:
  - IDLE (line boundary).
  - LINE (mid-line; busy = 1).
- Line start:
  - In IDLE, bcast_mode is latched as mode.
  - An input beat is accepted only if enable = 1; this sets busy.
  - In LINE, enable is ignored: a started line always completes.
- s_axis_tready, combinational from registered state only, with no path from m*_tready:
  - mode 0: (IDLE ? enable : 1) && cnt[sel] < 2.
  - mode 1: (IDLE ? enable : 1) && cnt0 < 2 && cnt1 < 2.
- Accepted beat:
  - It is pushed to FIFO[sel], or to both FIFOs in mode 1.
  - It is visible on m*_tvalid the cycle after acceptance (latency 1).
- Accepted beat with tlast = 1:
  - The FSM returns to IDLE.
  - In mode 0, sel toggles; in mode 1, sel is unchanged.
  - A beat with tlast = 1 accepted in IDLE is a single-beat line: it is pushed, sel toggles in mode 0, and the state stays IDLE.
- Line counters:
  - line_cnt_x increments by 1 on each m*_tvalid && m*_tready && m*_tlast.
  - Counters wrap modulo 2^CNT_WIDTH.
- sync_clear:
  - In IDLE it takes effect next cycle: sel = 0, counters = 0.
  - In LINE it is held pending and applied in the cycle the tlast beat is accepted; it overrides the sel toggle, so sel = 0.
  - The counter clear wins over a same-cycle increment (the result is 0).
  - FIFO contents are never flushed by sync_clear.
- Back-pressure: a stalled channel blocks the input only when it is the target of the current line. In mode 0, a stalled ch1 does not block lines going to ch0 until sel returns to ch1.
- Full throughput: one beat per cycle is sustained with m*_tready held high, since the FIFO stays at occupancy ≤ 1.
- Ordering: beats within a channel leave in input order; no beat is ever dropped or duplicated except by mode 1 duplication.
- Async reset mid-line: all state is cleared and any partial line is discarded. Upstream is reset by the same rst_n.

Test Plan:
- Mode 0, enable = 1, 4 lines of 3 beats (data = beat index 0..11), both m*_tready = 1:
  - Lines 0 and 2 (data 0-2, 6-8) appear on ch0; lines 1 and 3 on ch1.
  - Each beat appears 1 cycle after acceptance.
  - Final line_cnt_0 = 2, line_cnt_1 = 2; s_axis_tready is never low.
- Mode 1, 2 lines of 4 beats:
  - Both channels output the identical 8 beats with tlast on beats 3 and 7; line_cnt_0 = line_cnt_1 = 2.
  - With m1_tready held 0, s_axis_tready drops after 2 beats, and those 2 beats are still sent on ch0.
- enable deasserted on the 2nd beat of a 5-beat line:
  - The remaining 3 beats are accepted.
  - The next line is not accepted (s_axis_tready = 0) until enable = 1.
- sync_clear pulsed mid-line while sel = 1, with line_cnt_1 = 7:
  - Counters are unchanged until the tlast is accepted; then line_cnt = 0 and sel = 0.
  - The next line goes to ch0.
- Mode 0 with m1_tready = 0 and a ch1 line pending:
  - The ch1 FIFO fills to 2; s_axis_tready = 0 while sel = 1.
  - Releasing m1_tready drains the FIFO in order and input resumes.
- Counter wrap with CNT_WIDTH = 4: 17 single-beat lines in mode 1 → line_cnt_0 = line_cnt_1 = 1.
- rst_n asserted mid-line: all outputs reach reset values immediately; after release the first line goes to ch0.

Source files
------------

// File: rtl/tdi_axis_line_splitter.sv
// TDI line splitter: routes whole AXI-Stream lines from one input to two
// RDMA channels, alternating line by line or duplicating each line to both.
// Each channel has a 2-deep output FIFO. Input ready depends only on
// registered state and enable, so there is no ready path from the outputs.
module tdi_axis_line_splitter #(
   parameter int DATA_WIDTH = 512,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  bcast_mode,
   input  logic                  sync_clear,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m0_axis_tdata,
   output logic                  m0_axis_tvalid,
   input  logic                  m0_axis_tready,
   output logic                  m0_axis_tlast,
   output logic [DATA_WIDTH-1:0] m1_axis_tdata,
   output logic                  m1_axis_tvalid,
   input  logic                  m1_axis_tready,
   output logic                  m1_axis_tlast,
   output logic [CNT_WIDTH-1:0]  line_cnt_0,
   output logic [CNT_WIDTH-1:0]  line_cnt_1,
   output logic                  busy
);

   typedef enum logic {S_IDLE = 1'b0, S_LINE = 1'b1} state_t;

   state_t state_reg, state_next;
   logic   sel_reg, sel_next;
   logic   mode_reg, mode_next;
   logic   clr_pend_reg, clr_pend_next;
   logic   run_reg;

   logic   cur_mode, room, accept, line_end, clr_req, clr_now;
   logic [1:0] push, pop, m_ready, m_valid, m_last, fifo_space;
   logic [1:0][DATA_WIDTH-1:0] m_data;
   logic [1:0][CNT_WIDTH-1:0]  line_cnt;

   assign m_ready  = {m1_axis_tready, m0_axis_tready};
   assign accept   = s_axis_tvalid && s_axis_tready;
   assign line_end = accept && s_axis_tlast;
   // The first beat of a line is routed with the live mode; later beats use the latched one.
   assign push[0]  = accept && (cur_mode || !sel_reg);
   assign push[1]  = accept && (cur_mode ||  sel_reg);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   // FSM next state: a non-last beat opens a line, the tlast beat closes it
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (accept && !s_axis_tlast) state_next = S_LINE;
         S_LINE:  if (line_end)                state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // FSM outputs: busy flag and input ready (enable gates only line starts)
   always_comb begin
      busy     = (state_reg == S_LINE);
      cur_mode = (state_reg == S_IDLE) ? bcast_mode : mode_reg;
      if (cur_mode) room = fifo_space[0] && fifo_space[1];
      else          room = fifo_space[sel_reg];
      s_axis_tready = run_reg && ((state_reg == S_IDLE) ? enable : 1'b1) && room;
   end

   // Channel pointer, mode latch and deferred sync_clear
   always_comb begin
      clr_req = clr_pend_reg || sync_clear;
      // A clear never splits a line: in IDLE it applies unless a multi-beat line is starting.
      clr_now = clr_req && (((state_reg == S_IDLE) && !(accept && !s_axis_tlast)) || line_end);
      clr_pend_next = clr_req && !clr_now;
      mode_next = (state_reg == S_IDLE) ? bcast_mode : mode_reg;
      if (clr_now)                    sel_next = 1'b0;
      else if (line_end && !cur_mode) sel_next = !sel_reg;
      else                            sel_next = sel_reg;
   end

   // Control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_reg      <= 1'b0;
         mode_reg     <= 1'b0;
         clr_pend_reg <= 1'b0;
         run_reg      <= 1'b0;
      end else begin
         sel_reg      <= sel_next;
         mode_reg     <= mode_next;
         clr_pend_reg <= clr_pend_next;
         run_reg      <= 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         logic [DATA_WIDTH:0]  mem_reg [2];
         logic                 wr_ptr_reg, rd_ptr_reg;
         logic [1:0]           cnt_reg;
         logic [CNT_WIDTH-1:0] lcnt_reg;

         assign m_valid[gi]    = (cnt_reg != 2'd0);
         assign pop[gi]        = m_valid[gi] && m_ready[gi];
         assign fifo_space[gi] = (cnt_reg != 2'd2);
         assign m_data[gi]     = mem_reg[rd_ptr_reg][DATA_WIDTH-1:0];
         assign m_last[gi]     = mem_reg[rd_ptr_reg][DATA_WIDTH];
         assign line_cnt[gi]   = lcnt_reg;

         // Two-entry FIFO of {tlast, tdata}; head entry drives the channel outputs
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               mem_reg[0] <= '0;
               mem_reg[1] <= '0;
               wr_ptr_reg <= 1'b0;
               rd_ptr_reg <= 1'b0;
               cnt_reg    <= 2'd0;
            end else begin
               if (push[gi]) begin
                  mem_reg[wr_ptr_reg] <= {s_axis_tlast, s_axis_tdata};
                  wr_ptr_reg          <= !wr_ptr_reg;
               end
               if (pop[gi]) rd_ptr_reg <= !rd_ptr_reg;
               case ({push[gi], pop[gi]})
                  2'b10:   cnt_reg <= cnt_reg + 2'd1;
                  2'b01:   cnt_reg <= cnt_reg - 2'd1;
                  default: cnt_reg <= cnt_reg;
               endcase
            end
         end

         // Delivered-line counter; clear wins over a same-cycle increment
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                       lcnt_reg <= '0;
            else if (clr_now)                 lcnt_reg <= '0;
            else if (pop[gi] && m_last[gi])   lcnt_reg <= lcnt_reg + 1'b1;
         end
      end
   endgenerate

   assign m0_axis_tdata  = m_data[0];
   assign m0_axis_tvalid = m_valid[0];
   assign m0_axis_tlast  = m_last[0];
   assign m1_axis_tdata  = m_data[1];
   assign m1_axis_tvalid = m_valid[1];
   assign m1_axis_tlast  = m_last[1];
   assign line_cnt_0     = line_cnt[0];
   assign line_cnt_1     = line_cnt[1];

endmodule

// File: tb/tb_tdi_axis_line_splitter.sv
// Directed bench for tdi_axis_line_splitter: a cycle table for alternating
// mode plus hand-written sequences for broadcast, back-pressure, enable
// gating, deferred sync_clear, counter wrap and asynchronous reset.
`timescale 1ns/1ps
module tb_tdi_axis_line_splitter;
   localparam int DW = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0, bcast_mode = 1'b0, sync_clear = 1'b0;
   logic [DW-1:0] s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0;
   logic          s_axis_tready;
   logic [DW-1:0] m0_axis_tdata, m1_axis_tdata;
   logic          m0_axis_tvalid, m0_axis_tlast, m1_axis_tvalid, m1_axis_tlast;
   logic          m0_axis_tready = 1'b1, m1_axis_tready = 1'b1;
   logic [CW-1:0] line_cnt_0, line_cnt_1;
   logic          busy;

   int n_chk = 0;
   int n_fail = 0;

   tdi_axis_line_splitter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .bcast_mode(bcast_mode),
      .sync_clear(sync_clear),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .m0_axis_tdata(m0_axis_tdata), .m0_axis_tvalid(m0_axis_tvalid),
      .m0_axis_tready(m0_axis_tready), .m0_axis_tlast(m0_axis_tlast),
      .m1_axis_tdata(m1_axis_tdata), .m1_axis_tvalid(m1_axis_tvalid),
      .m1_axis_tready(m1_axis_tready), .m1_axis_tlast(m1_axis_tlast),
      .line_cnt_0(line_cnt_0), .line_cnt_1(line_cnt_1), .busy(busy)
   );

   always #5 clk = ~clk;

   // Output capture, sampled on the falling edge
   logic [DW:0] q0[$];
   logic [DW:0] q1[$];
   always @(negedge clk) begin
      if (rst_n) begin
         if (m0_axis_tvalid && m0_axis_tready) q0.push_back({m0_axis_tlast, m0_axis_tdata});
         if (m1_axis_tvalid && m1_axis_tready) q1.push_back({m1_axis_tlast, m1_axis_tdata});
      end
   end

   typedef struct {
      logic          sv;
      logic [DW-1:0] sd;
      logic          sl;
      logic          e_srdy;
      logic          e_v0;
      logic [DW-1:0] e_d0;
      logic          e_l0;
      logic          e_v1;
      logic [DW-1:0] e_d1;
      logic          e_l1;
      logic          e_busy;
      logic [CW-1:0] e_c0;
      logic [CW-1:0] e_c1;
   } vec_t;

   localparam int NV = 14;
   vec_t vt [NV];

   task automatic setv(input int r, input logic sv, input int sd, input logic sl,
                       input logic srdy, input logic v0, input int d0, input logic l0,
                       input logic v1, input int d1, input logic l1, input logic bz,
                       input int c0, input int c1);
      vt[r].sv = sv;   vt[r].sd = DW'(sd);  vt[r].sl = sl;
      vt[r].e_srdy = srdy;
      vt[r].e_v0 = v0; vt[r].e_d0 = DW'(d0); vt[r].e_l0 = l0;
      vt[r].e_v1 = v1; vt[r].e_d1 = DW'(d1); vt[r].e_l1 = l1;
      vt[r].e_busy = bz;
      vt[r].e_c0 = CW'(c0); vt[r].e_c1 = CW'(c1);
   endtask

   task automatic chk(input string nm, input logic [DW:0] act, input logic [DW:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic l);
      int  waited;
      bit  done;
      waited = 0;
      done = 1'b0;
      s_axis_tdata = d;
      s_axis_tlast = l;
      s_axis_tvalid = 1'b1;
      while (!done && waited < 50) begin
         @(negedge clk);
         if (s_axis_tready) done = 1'b1;
         step();
         waited++;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
      if (!done) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: beat %0h not accepted, expected acceptance within 50 cycles", d);
      end
   endtask

   task automatic exp_pop(input int ch, input logic [DW-1:0] d, input logic l);
      logic [DW:0] got;
      bit ok;
      ok = 1'b0;
      got = '0;
      if (ch == 0 && q0.size() > 0) begin got = q0.pop_front(); ok = 1'b1; end
      if (ch == 1 && q1.size() > 0) begin got = q1.pop_front(); ok = 1'b1; end
      n_chk++;
      if (!ok || got !== {l, d}) begin
         n_fail++;
         $display("FAIL ch%0d_beat: got %0h (present=%0b), expected %0h", ch, got, ok, {l, d});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;

      // Alternating-mode cycle table: 4 lines of 3 beats, data = beat index
      setv( 0, 1,  0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      setv( 1, 1,  1, 0, 1, 1, 0, 0, 0,  0, 0, 1, 0, 0);
      setv( 2, 1,  2, 1, 1, 1, 1, 0, 0,  0, 0, 1, 0, 0);
      setv( 3, 1,  3, 0, 1, 1, 2, 1, 0,  0, 0, 0, 0, 0);
      setv( 4, 1,  4, 0, 1, 0, 0, 0, 1,  3, 0, 1, 1, 0);
      setv( 5, 1,  5, 1, 1, 0, 0, 0, 1,  4, 0, 1, 1, 0);
      setv( 6, 1,  6, 0, 1, 0, 0, 0, 1,  5, 1, 0, 1, 0);
      setv( 7, 1,  7, 0, 1, 1, 6, 0, 0,  0, 0, 1, 1, 1);
      setv( 8, 1,  8, 1, 1, 1, 7, 0, 0,  0, 0, 1, 1, 1);
      setv( 9, 1,  9, 0, 1, 1, 8, 1, 0,  0, 0, 0, 1, 1);
      setv(10, 1, 10, 0, 1, 0, 0, 0, 1,  9, 0, 1, 2, 1);
      setv(11, 1, 11, 1, 1, 0, 0, 0, 1, 10, 0, 1, 2, 1);
      setv(12, 0,  0, 0, 1, 0, 0, 0, 1, 11, 1, 0, 2, 1);
      setv(13, 0,  0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 2, 2);

      // Reset values, with enable and valid already high
      rst_n = 1'b0; enable = 1'b1; s_axis_tvalid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_tready", s_axis_tready, 0);
      chk("rst_m0_valid", m0_axis_tvalid, 0);
      chk("rst_m1_valid", m1_axis_tvalid, 0);
      chk("rst_m0_data", {m0_axis_tlast, m0_axis_tdata}, 0);
      chk("rst_m1_data", {m1_axis_tlast, m1_axis_tdata}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cnt0", line_cnt_0, 0);
      chk("rst_cnt1", line_cnt_1, 0);
      s_axis_tvalid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      step();

      for (int r = 0; r < NV; r++) begin
         s_axis_tvalid = vt[r].sv;
         s_axis_tdata  = vt[r].sd;
         s_axis_tlast  = vt[r].sl;
         @(negedge clk);
         chk($sformatf("t%0d_tready", r), s_axis_tready, vt[r].e_srdy);
         chk($sformatf("t%0d_m0_valid", r), m0_axis_tvalid, vt[r].e_v0);
         if (vt[r].e_v0) chk($sformatf("t%0d_m0_beat", r), {m0_axis_tlast, m0_axis_tdata}, {vt[r].e_l0, vt[r].e_d0});
         chk($sformatf("t%0d_m1_valid", r), m1_axis_tvalid, vt[r].e_v1);
         if (vt[r].e_v1) chk($sformatf("t%0d_m1_beat", r), {m1_axis_tlast, m1_axis_tdata}, {vt[r].e_l1, vt[r].e_d1});
         chk($sformatf("t%0d_busy", r), busy, vt[r].e_busy);
         chk($sformatf("t%0d_cnt0", r), line_cnt_0, vt[r].e_c0);
         chk($sformatf("t%0d_cnt1", r), line_cnt_1, vt[r].e_c1);
         step();
      end
      s_axis_tvalid = 1'b0;
      for (int i = 0; i < 12; i++) exp_pop(((i / 3) % 2), DW'(i), (i % 3) == 2);
      chk("alt_q0_extra", q0.size(), 0);
      chk("alt_q1_extra", q1.size(), 0);

      // sync_clear while idle clears the counters on the next cycle
      sync_clear = 1'b1; step(); sync_clear = 1'b0;
      @(negedge clk);
      chk("idle_clr_cnt0", line_cnt_0, 0);
      chk("idle_clr_cnt1", line_cnt_1, 0);
      step();

      // Broadcast: 2 lines of 4 beats to both channels
      bcast_mode = 1'b1;
      q0.delete(); q1.delete();
      for (int i = 0; i < 8; i++) send_beat(DW'(100 + i), (i % 4) == 3);
      idle(4);
      for (int i = 0; i < 8; i++) begin
         exp_pop(0, DW'(100 + i), (i % 4) == 3);
         exp_pop(1, DW'(100 + i), (i % 4) == 3);
      end
      @(negedge clk);
      chk("bc_cnt0", line_cnt_0, 2);
      chk("bc_cnt1", line_cnt_1, 2);
      step();

      // Broadcast with ch1 stalled: input stops after 2 beats, ch0 still receives them
      m1_axis_tready = 1'b0;
      acc = 0;
      s_axis_tvalid = 1'b1; s_axis_tdata = DW'(200); s_axis_tlast = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (s_axis_tready) acc++;
         step();
         s_axis_tdata = DW'(200 + acc);
         s_axis_tlast = (acc == 3);
      end
      chk("bc_stall_accepted", acc, 2);
      @(negedge clk);
      chk("bc_stall_tready", s_axis_tready, 0);
      chk("bc_stall_busy", busy, 1);
      chk("bc_stall_m1_head", {m1_axis_tvalid, m1_axis_tdata}, {1'b1, DW'(200)});
      exp_pop(0, DW'(200), 0);
      exp_pop(0, DW'(201), 0);
      step();
      m1_axis_tready = 1'b1;
      send_beat(DW'(202), 1'b0);
      send_beat(DW'(203), 1'b1);
      idle(4);
      exp_pop(0, DW'(202), 0);
      exp_pop(0, DW'(203), 1);
      for (int i = 0; i < 4; i++) exp_pop(1, DW'(200 + i), i == 3);
      @(negedge clk);
      chk("bc_stall_cnt0", line_cnt_0, 3);
      chk("bc_stall_cnt1", line_cnt_1, 3);
      step();

      // enable drops during a line: the line completes, the next one waits
      bcast_mode = 1'b0;
      q0.delete(); q1.delete();
      send_beat(DW'(300), 1'b0);
      enable = 1'b0;
      for (int i = 1; i < 5; i++) send_beat(DW'(300 + i), i == 4);
      s_axis_tvalid = 1'b1; s_axis_tdata = DW'(310); s_axis_tlast = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("en_gate_tready%0d", c), s_axis_tready, 0);
         chk($sformatf("en_gate_busy%0d", c), busy, 0);
         step();
      end
      enable = 1'b1;
      send_beat(DW'(310), 1'b1);
      idle(3);
      for (int i = 0; i < 5; i++) exp_pop(0, DW'(300 + i), i == 4);
      exp_pop(1, DW'(310), 1);

      // Bring counters to ch0 = 8, ch1 = 7 with sel pointing at ch1
      sync_clear = 1'b1; step(); sync_clear = 1'b0;
      for (int i = 0; i < 15; i++) send_beat(DW'(600 + i), 1'b1);
      idle(3);
      @(negedge clk);
      chk("pre_clr_cnt0", line_cnt_0, 8);
      chk("pre_clr_cnt1", line_cnt_1, 7);
      step();
      q0.delete(); q1.delete();

      // sync_clear mid-line on ch1 is deferred to the tlast acceptance
      send_beat(DW'(400), 1'b0);
      sync_clear = 1'b1;
      send_beat(DW'(401), 1'b0);
      sync_clear = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("pend_cnt1_%0d", c), line_cnt_1, 7);
         chk($sformatf("pend_cnt0_%0d", c), line_cnt_0, 8);
         chk($sformatf("pend_busy_%0d", c), busy, 1);
         step();
      end
      send_beat(DW'(402), 1'b1);
      @(negedge clk);
      chk("clr_cnt0", line_cnt_0, 0);
      chk("clr_cnt1", line_cnt_1, 0);
      step();
      @(negedge clk);
      chk("clr_then_deliver_cnt1", line_cnt_1, 1);
      step();
      send_beat(DW'(410), 1'b1);
      idle(3);
      exp_pop(1, DW'(400), 0);
      exp_pop(1, DW'(401), 0);
      exp_pop(1, DW'(402), 1);
      exp_pop(0, DW'(410), 1);

      // Alternating mode with ch1 stalled: FIFO fills to 2, then drains in order
      q0.delete(); q1.delete();
      m1_axis_tready = 1'b0;
      acc = 0;
      s_axis_tvalid = 1'b1; s_axis_tdata = DW'(500); s_axis_tlast = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (s_axis_tready) acc++;
         step();
         s_axis_tdata = DW'(500 + acc);
         s_axis_tlast = (acc == 3);
      end
      chk("alt_stall_accepted", acc, 2);
      @(negedge clk);
      chk("alt_stall_tready", s_axis_tready, 0);
      chk("alt_stall_m1_head", {m1_axis_tvalid, m1_axis_tdata}, {1'b1, DW'(500)});
      step();
      m1_axis_tready = 1'b1;
      send_beat(DW'(502), 1'b0);
      send_beat(DW'(503), 1'b1);
      idle(4);
      for (int i = 0; i < 4; i++) exp_pop(1, DW'(500 + i), i == 3);
      chk("alt_stall_q0_empty", q0.size(), 0);

      // Counter wrap: 17 single-beat broadcast lines on a 4-bit counter
      sync_clear = 1'b1; step(); sync_clear = 1'b0;
      bcast_mode = 1'b1;
      for (int i = 0; i < 17; i++) send_beat(DW'(800 + i), 1'b1);
      idle(3);
      @(negedge clk);
      chk("wrap_cnt0", line_cnt_0, 1);
      chk("wrap_cnt1", line_cnt_1, 1);
      step();

      // Asynchronous reset in the middle of a ch1 line
      bcast_mode = 1'b0;
      send_beat(DW'(900), 1'b1);
      idle(2);
      m1_axis_tready = 1'b0;
      send_beat(DW'(701), 1'b0);
      send_beat(DW'(702), 1'b0);
      #1;
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_m1_valid", m1_axis_tvalid, 0);
      chk("arst_m1_data", {m1_axis_tlast, m1_axis_tdata}, 0);
      chk("arst_tready", s_axis_tready, 0);
      chk("arst_busy", busy, 0);
      chk("arst_cnt0", line_cnt_0, 0);
      m1_axis_tready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      step();
      q0.delete(); q1.delete();
      send_beat(DW'(710), 1'b1);
      idle(3);
      exp_pop(0, DW'(710), 1);
      chk("arst_q1_empty", q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
